gc_refresh_scheduler: RTL and testbench

// - Sequences periodic refresh of the 128-row gain-cell DRAM array.
// - Shares the single array command port between the user requester and the internal refresh sweep.
// - Keeps a per-sweep "row already refreshed" bitmap, so rows restored by user traffic are skipped.
// - Sits between the user port and the array macro.
// - Raises refresh priority over users when the retention deadline is near.

---
 rtl/gc_refresh_scheduler_if.sv | 37 +++
 rtl/gc_refresh_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_gc_refresh_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/gc_refresh_scheduler_if.sv
// Bundle of the user request port, the array command port and the refresh
// status flags seen by the gain-cell refresh scheduler.
interface gc_refresh_scheduler_if #(
    parameter int ADDR_W = 7
);
    // User requester side
    logic              ref_start;
    logic              user_valid;
    logic              user_we;
    logic [ADDR_W-1:0] user_addr;
    logic              user_ready;

    // Array macro command side
    logic              arr_en;
    logic              arr_we;
    logic              arr_ref;
    logic [ADDR_W-1:0] arr_addr;

    // Refresh status
    logic              ref_active;
    logic              ref_done;
    logic              ref_overrun;

    // Environment side: issues user commands, consumes array commands and status
    modport master (
        output ref_start, user_valid, user_we, user_addr,
        input  user_ready, arr_en, arr_we, arr_ref, arr_addr,
        input  ref_active, ref_done, ref_overrun
    );

    // Scheduler side
    modport slave (
        input  ref_start, user_valid, user_we, user_addr,
        output user_ready, arr_en, arr_we, arr_ref, arr_addr,
        output ref_active, ref_done, ref_overrun
    );
endinterface

// File: rtl/gc_refresh_scheduler.sv
// Refresh scheduler for a gain-cell DRAM array. Arbitrates the single array
// command port between user traffic and a row-by-row refresh sweep, skips rows
// already restored by user traffic during the current sweep, and stalls users
// when the retention deadline leaves too little slack to finish the sweep.
module gc_refresh_scheduler #(
    parameter int ADDR_W       = 7,
    parameter int ROWS         = 128,
    parameter int RET_CYCLES   = 4096,
    parameter int FORCE_MARGIN = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    gc_refresh_scheduler_if.slave  bus
);
    localparam int TMR_W = $clog2(RET_CYCLES);
    localparam int PTR_W = ADDR_W + 1;

    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(RET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] ROWS_T     = TMR_W'(ROWS);
    localparam logic [TMR_W-1:0] MARGIN_T   = TMR_W'(FORCE_MARGIN);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_END    = PTR_W'(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_FORCE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [ROWS-1:0]   bitmap_q, bitmap_d;
    logic              arr_en_q, arr_en_d;
    logic              arr_we_q, arr_we_d;
    logic              arr_ref_q, arr_ref_d;
    logic [ADDR_W-1:0] arr_addr_q, arr_addr_d;
    logic              ref_done_q, ref_done_d;
    logic              overrun_q, overrun_d;

    logic              expire_s;
    logic              active_s;
    logic              user_ready_s;
    logic              accept_s;
    logic              ptr_adv_s;
    logic              complete_s;
    logic              clear_s;
    logic              restart_s;
    logic              slack_low_s;
    logic [TMR_W-1:0]  slack_s;
    logic [PTR_W-1:0]  ptr_inc_s;
    logic [ADDR_W-1:0] ptr_row_s;
    logic              set_en_s;
    logic [ADDR_W-1:0] set_idx_s;

    assign ptr_row_s = ptr_q[ADDR_W-1:0];
    assign ptr_inc_s = ptr_q + PTR_ONE;
    assign expire_s  = (tmr_q == TMR_ZERO);
    assign accept_s  = bus.user_valid & user_ready_s;

    // Remaining rows plus margin, compared unsigned against the retention timer
    always_comb begin
        slack_s     = ROWS_T - TMR_W'(ptr_q) + MARGIN_T;
        slack_low_s = (tmr_q < slack_s);
    end

    // Retention timer: free-running down-counter, reloaded on wrap or sweep request
    always_comb begin
        if ((state_q == ST_IDLE) && bus.ref_start) begin
            tmr_d = TMR_RELOAD;
        end else if (expire_s) begin
            tmr_d = TMR_RELOAD;
        end else begin
            tmr_d = tmr_q - TMR_ONE;
        end
    end

    // FSM next state: expire has priority over entering FORCE; completion wins over expire
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (expire_s || bus.ref_start) begin
                    state_d = ST_SWEEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (complete_s) begin
                    state_d = expire_s ? ST_SWEEP : ST_IDLE;
                end else if (expire_s) begin
                    state_d = ST_SWEEP;
                end else if (slack_low_s) begin
                    state_d = ST_FORCE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            ST_FORCE: begin
                if (complete_s) begin
                    state_d = expire_s ? ST_SWEEP : ST_IDLE;
                end else if (expire_s) begin
                    state_d = ST_SWEEP;
                end else begin
                    state_d = ST_FORCE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: sweep activity and user admission (no admission while in reset)
    always_comb begin
        active_s     = 1'b0;
        user_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                active_s     = 1'b0;
                user_ready_s = rst;
            end
            ST_SWEEP: begin
                active_s     = 1'b1;
                user_ready_s = rst;
            end
            ST_FORCE: begin
                active_s     = 1'b1;
                user_ready_s = 1'b0;
            end
            default: begin
                active_s     = 1'b0;
                user_ready_s = 1'b0;
            end
        endcase
    end

    // Op selection: one array op per cycle, user first, otherwise a sweep step
    always_comb begin
        arr_en_d   = 1'b0;
        arr_we_d   = 1'b0;
        arr_ref_d  = 1'b0;
        arr_addr_d = {ADDR_W{1'b0}};
        set_en_s   = 1'b0;
        set_idx_s  = {ADDR_W{1'b0}};
        ptr_adv_s  = 1'b0;
        if (accept_s) begin
            arr_en_d   = 1'b1;
            arr_addr_d = bus.user_addr;
            set_idx_s  = bus.user_addr;
            if (bus.user_we) begin
                arr_we_d = 1'b1;
                set_en_s = active_s;
            end else if (active_s && !bitmap_q[bus.user_addr]) begin
                // First read of this row in the sweep doubles as its refresh
                arr_ref_d = 1'b1;
                set_en_s  = 1'b1;
            end else begin
                arr_ref_d = 1'b0;
            end
            // Pointer may still move past a row already covered earlier
            ptr_adv_s = active_s & bitmap_q[ptr_row_s];
        end else if (active_s) begin
            ptr_adv_s = 1'b1;
            if (!bitmap_q[ptr_row_s]) begin
                arr_en_d   = 1'b1;
                arr_ref_d  = 1'b1;
                arr_addr_d = ptr_row_s;
                set_en_s   = 1'b1;
                set_idx_s  = ptr_row_s;
            end else begin
                arr_en_d = 1'b0;
            end
        end else begin
            ptr_adv_s = 1'b0;
        end
    end

    // Sweep bookkeeping: completion, restart on missed deadline, bitmap and pointer
    always_comb begin
        complete_s = ptr_adv_s && (ptr_inc_s == PTR_END);
        restart_s  = active_s && expire_s && !complete_s;
        clear_s    = complete_s || restart_s;
        bitmap_d   = bitmap_q;
        if (set_en_s) begin
            bitmap_d[set_idx_s] = 1'b1;
        end else begin
            bitmap_d = bitmap_q;
        end
        if (clear_s) begin
            bitmap_d = {ROWS{1'b0}};
            ptr_d    = PTR_ZERO;
        end else if (ptr_adv_s) begin
            ptr_d = ptr_inc_s;
        end else begin
            ptr_d = ptr_q;
        end
        ref_done_d = complete_s;
        overrun_d  = overrun_q | restart_s;
    end

    // State, timer, sweep tracking and registered array/status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tmr_q      <= TMR_RELOAD;
            ptr_q      <= PTR_ZERO;
            bitmap_q   <= {ROWS{1'b0}};
            arr_en_q   <= 1'b0;
            arr_we_q   <= 1'b0;
            arr_ref_q  <= 1'b0;
            arr_addr_q <= {ADDR_W{1'b0}};
            ref_done_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ptr_q      <= ptr_d;
            bitmap_q   <= bitmap_d;
            arr_en_q   <= arr_en_d;
            arr_we_q   <= arr_we_d;
            arr_ref_q  <= arr_ref_d;
            arr_addr_q <= arr_addr_d;
            ref_done_q <= ref_done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.user_ready  = user_ready_s;
    assign bus.arr_en      = arr_en_q;
    assign bus.arr_we      = arr_we_q;
    assign bus.arr_ref     = arr_ref_q;
    assign bus.arr_addr    = arr_addr_q;
    assign bus.ref_active  = active_s;
    assign bus.ref_done    = ref_done_q;
    assign bus.ref_overrun = overrun_q;
endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// Directed bench for gc_refresh_scheduler. Three instances cover the default
// retention window, a short window for user stalling, and a zero-margin short
// window that misses its deadline. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_gc_refresh_scheduler;
    logic clk;
    logic rst0, rst1, rst2;
    int   n_checks;
    int   n_errors;
    int   bad, good, refs, others, done, first_low;

    gc_refresh_scheduler_if #(.ADDR_W(7)) if0 ();
    gc_refresh_scheduler_if #(.ADDR_W(7)) if1 ();
    gc_refresh_scheduler_if #(.ADDR_W(7)) if2 ();

    gc_refresh_scheduler #(.ADDR_W(7), .ROWS(128), .RET_CYCLES(4096), .FORCE_MARGIN(16))
        u0 (.clk(clk), .rst(rst0), .bus(if0));
    gc_refresh_scheduler #(.ADDR_W(7), .ROWS(128), .RET_CYCLES(256), .FORCE_MARGIN(16))
        u1 (.clk(clk), .rst(rst1), .bus(if1));
    gc_refresh_scheduler #(.ADDR_W(7), .ROWS(128), .RET_CYCLES(130), .FORCE_MARGIN(0))
        u2 (.clk(clk), .rst(rst2), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        if0.ref_start = 1'b0; if0.user_valid = 1'b0; if0.user_we = 1'b0; if0.user_addr = 7'd0;
        if1.ref_start = 1'b0; if1.user_valid = 1'b0; if1.user_we = 1'b0; if1.user_addr = 7'd0;
        if2.ref_start = 1'b0; if2.user_valid = 1'b0; if2.user_we = 1'b0; if2.user_addr = 7'd0;

        // ---- Reset state ----
        repeat (3) @(negedge clk);
        check("rst_outputs", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr,
                              if0.ref_active, if0.ref_done, if0.ref_overrun, if0.user_ready}, 32'd0);

        // ---- Idle sweep: first sweep starts 4096 cycles after release ----
        rst0 = 1'b1;
        bad = 0;
        for (int k = 1; k <= 4095; k++) begin
            @(negedge clk);
            if (if0.arr_en !== 1'b0 || if0.ref_active !== 1'b0) bad++;
        end
        check("idle_quiet", bad, 32'd0);
        check("idle_ready", if0.user_ready, 32'd1);
        @(negedge clk);
        check("idle_sweep_active", if0.ref_active, 32'd1);
        check("idle_sweep_noop", if0.arr_en, 32'd0);
        good = 0;
        for (int r = 0; r < 128; r++) begin
            @(negedge clk);
            if (if0.arr_en === 1'b1 && if0.arr_ref === 1'b1 && if0.arr_we === 1'b0 &&
                if0.arr_addr === 7'(r)) good++;
            if (r == 126) check("idle_done_early", if0.ref_done, 32'd0);
        end
        check("idle_rows_in_order", good, 32'd128);
        check("idle_done", if0.ref_done, 32'd1);
        check("idle_back_to_idle", if0.ref_active, 32'd0);
        @(negedge clk);
        check("idle_done_single", if0.ref_done, 32'd0);
        check("idle_after_noop", if0.arr_en, 32'd0);

        // ---- Write skip: user writes rows 5 and 6 early in the sweep ----
        if0.ref_start = 1'b1;
        @(negedge clk);
        if0.ref_start = 1'b0;
        check("ws_active", if0.ref_active, 32'd1);
        if0.user_valid = 1'b1; if0.user_we = 1'b1; if0.user_addr = 7'd5;
        @(negedge clk);
        check("ws_wr5", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b110, 7'd5});
        if0.user_addr = 7'd6;
        @(negedge clk);
        check("ws_wr6", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b110, 7'd6});
        if0.user_valid = 1'b0; if0.user_we = 1'b0;
        refs = 0; bad = 0; others = 0; done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            @(negedge clk);
            if (if0.arr_en === 1'b1) begin
                if (if0.arr_ref === 1'b1) begin
                    refs++;
                    if (if0.arr_addr == 7'd5 || if0.arr_addr == 7'd6) bad++;
                end else begin
                    others++;
                end
            end
            if (if0.ref_done === 1'b1) done = 1;
        end
        check("ws_ref_count", refs, 32'd126);
        check("ws_no_ref_5_6", bad, 32'd0);
        check("ws_no_other_ops", others, 32'd0);
        check("ws_done_seen", done, 32'd1);

        // ---- Read-restore: read of row 90 at ptr=10, then a plain re-read ----
        @(negedge clk);
        if0.ref_start = 1'b1;
        @(negedge clk);
        if0.ref_start = 1'b0;
        repeat (10) @(negedge clk);
        check("rr_row9", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b101, 7'd9});
        if0.user_valid = 1'b1; if0.user_we = 1'b0; if0.user_addr = 7'd90;
        @(negedge clk);
        check("rr_restore90", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b101, 7'd90});
        if0.user_valid = 1'b0;
        @(negedge clk);
        check("rr_row10", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b101, 7'd10});
        if0.user_valid = 1'b1;
        @(negedge clk);
        check("rr_plain90", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b100, 7'd90});
        if0.user_valid = 1'b0;
        refs = 0; bad = 0; done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            @(negedge clk);
            if (if0.arr_en === 1'b1 && if0.arr_ref === 1'b1) begin
                refs++;
                if (if0.arr_addr == 7'd90) bad++;
            end
            if (if0.ref_done === 1'b1) done = 1;
        end
        check("rr_ref_count", refs, 32'd116);
        check("rr_row90_skipped", bad, 32'd0);
        check("rr_done_seen", done, 32'd1);

        // ---- Reset mid-sweep at ptr=40 ----
        @(negedge clk);
        if0.ref_start = 1'b1;
        @(negedge clk);
        if0.ref_start = 1'b0;
        repeat (40) @(negedge clk);
        check("rm_row39", if0.arr_addr, 32'd39);
        rst0 = 1'b0;
        @(negedge clk);
        check("rm_all_zero", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr,
                              if0.ref_active, if0.ref_done, if0.ref_overrun, if0.user_ready}, 32'd0);
        rst0 = 1'b1;
        bad = 0;
        for (int k = 1; k <= 4095; k++) begin
            @(negedge clk);
            if (if0.arr_en !== 1'b0 || if0.ref_active !== 1'b0) bad++;
        end
        check("rm_quiet", bad, 32'd0);
        @(negedge clk);
        check("rm_sweep_active", if0.ref_active, 32'd1);
        @(negedge clk);
        check("rm_first_row0", {if0.arr_en, if0.arr_we, if0.arr_ref, if0.arr_addr}, {3'b101, 7'd0});

        // ---- Force: continuous user reads from ref_start, 256-cycle window ----
        rst1 = 1'b1;
        if1.ref_start = 1'b1; if1.user_valid = 1'b1; if1.user_we = 1'b0; if1.user_addr = 7'd127;
        first_low = 0;
        for (int k = 1; k <= 300 && first_low == 0; k++) begin
            @(negedge clk);
            if1.ref_start = 1'b0;
            if (if1.user_ready === 1'b0) first_low = k;
        end
        check("fc_force_cycle", first_low, 32'd114);
        good = 0;
        for (int r = 0; r < 127; r++) begin
            @(negedge clk);
            if (if1.arr_en === 1'b1 && if1.arr_ref === 1'b1 && if1.arr_addr === 7'(r)) good++;
        end
        check("fc_back_to_back", good, 32'd127);
        @(negedge clk);
        check("fc_done", if1.ref_done, 32'd1);
        check("fc_row127_skipped", if1.arr_en, 32'd0);
        check("fc_ready_back", if1.user_ready, 32'd1);
        if1.user_valid = 1'b0;
        repeat (18) @(negedge clk);
        check("fc_no_overrun", if1.ref_overrun, 32'd0);

        // ---- Overrun: zero margin, 130-cycle window, 5 cycles of user writes ----
        rst2 = 1'b1;
        if2.ref_start = 1'b1;
        @(negedge clk);
        if2.ref_start = 1'b0;
        if2.user_valid = 1'b1; if2.user_we = 1'b1; if2.user_addr = 7'd120;
        repeat (3) @(negedge clk);
        check("ov_forced", if2.user_ready, 32'd0);
        repeat (2) @(negedge clk);
        if2.user_valid = 1'b0; if2.user_we = 1'b0;
        repeat (124) @(negedge clk);
        check("ov_before_expire", if2.ref_overrun, 32'd0);
        @(negedge clk);
        check("ov_set", if2.ref_overrun, 32'd1);
        check("ov_last_row", {if2.arr_en, if2.arr_we, if2.arr_ref, if2.arr_addr}, {3'b101, 7'd126});
        check("ov_no_done", if2.ref_done, 32'd0);
        @(negedge clk);
        check("ov_restart_row0", {if2.arr_en, if2.arr_we, if2.arr_ref, if2.arr_addr}, {3'b101, 7'd0});
        check("ov_restart_active", if2.ref_active, 32'd1);
        repeat (9) @(negedge clk);
        check("ov_sticky", if2.ref_overrun, 32'd1);
        rst2 = 1'b0;
        @(negedge clk);
        check("ov_cleared_by_rst", if2.ref_overrun, 32'd0);
        check("ov_idle_after_rst", if2.ref_active, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
